// File: rtl/euler_result_tx_pkg.sv
// rtl/euler_result_tx_pkg.sv - shared types and constants for the Euler result transmitter
package euler_result_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SEND = 2'd2,
        ST_TERM = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NL   = 8'h0A;

    // ceil(width * log10(2)) using 30103/100000 as the integer approximation of log10(2)
    function automatic int digits_for(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/euler_result_tx_if.sv
// rtl/euler_result_tx_if.sv - valid/ready byte stream carrying ASCII digits to the sink
interface euler_result_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/euler_result_tx_bin2bcd_seq.sv
// rtl/euler_result_tx_bin2bcd_seq.sv - sequential double-dabble, one bit per clock
module bin2bcd_seq #(
    parameter int DATA_W = 24,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     data,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]   shift_q;
    logic [CNT_W-1:0]    bit_cnt;
    logic [4*DIGITS-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // The load cycle already performs the first step: with BCD cleared no nibble
    // needs correction, so the MSB goes straight into digit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                shift_q <= {data[DATA_W-2:0], 1'b0};
                bcd     <= {{(4*DIGITS-1){1'b0}}, data[DATA_W-1]};
                bit_cnt <= CNT_W'(1);
                busy    <= 1'b1;
            end else if (busy) begin
                bcd     <= {adj[4*DIGITS-2:0], shift_q[DATA_W-1]};
                shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/euler_result_tx.sv
// rtl/euler_result_tx.sv - captures a solver result and streams it as ASCII decimal plus newline
module euler_result_tx
    import euler_result_tx_pkg::*;
#(
    parameter int         DATA_W  = 24,
    parameter int         DIGITS  = 8,
    parameter logic [7:0] NEWLINE = ASCII_NL
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               results_valid,
    input  logic [DATA_W-1:0]  results,
    output logic               busy,
    output logic               done,
    euler_result_tx_if.master  tx
);

    localparam int BCD_DIGITS = (DIGITS >= digits_for(DATA_W)) ? DIGITS : digits_for(DATA_W);
    localparam int PTR_W      = (BCD_DIGITS > 1) ? $clog2(BCD_DIGITS) : 1;

    state_t                  state_q, state_d;
    logic                    vld_q;
    logic [PTR_W-1:0]        ptr_q, ptr_d, top_ptr;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    conv_start, conv_busy, conv_done;
    logic [4*BCD_DIGITS-1:0] bcd;
    logic                    trigger, xfer;

    function automatic logic [7:0] digit_char(input logic [4*BCD_DIGITS-1:0] v,
                                              input logic [PTR_W-1:0]        idx);
        return ASCII_ZERO + {4'h0, v[{idx, 2'b00} +: 4]};
    endfunction

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (conv_start),
        .data    (results),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd     (bcd)
    );

    assign trigger = results_valid & ~vld_q & (state_q == ST_IDLE);
    assign xfer    = tx_valid_q & tx.tx_ready;

    // Leading-zero suppression: start from the most significant nonzero digit
    always_comb begin
        top_ptr = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                top_ptr = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        conv_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    conv_start = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_done && !conv_busy) begin
                    ptr_d      = top_ptr;
                    tx_data_d  = digit_char(bcd, top_ptr);
                    tx_valid_d = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (ptr_q == '0) begin
                        tx_data_d = NEWLINE;
                        state_d   = ST_TERM;
                    end else begin
                        ptr_d     = ptr_q - PTR_W'(1);
                        tx_data_d = digit_char(bcd, ptr_q - PTR_W'(1));
                    end
                end
            end
            ST_TERM: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            vld_q      <= 1'b0;
            ptr_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vld_q      <= results_valid;
            ptr_q      <= ptr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_euler_result_tx.sv
// tb/tb_euler_result_tx.sv - self-checking bench for euler_result_tx
module tb_euler_result_tx;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        results_valid = 1'b0;
    logic [23:0] results = '0;
    logic        busy, done;

    euler_result_tx_if tx_if();

    euler_result_tx #(
        .DATA_W  (24),
        .DIGITS  (8),
        .NEWLINE (8'h0A)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .results_valid (results_valid),
        .results       (results),
        .busy          (busy),
        .done          (done),
        .tx            (tx_if.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    byte_q_t got;
    byte_q_t exp_q;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the decimal text of the value followed by a newline
    function automatic byte_q_t model(input logic [23:0] v);
        byte_q_t q;
        string s;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        q.push_back(8'h0A);
        return q;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", tx_if.tx_valid, 1'b1);
                check("stall_data", tx_if.tx_data, stall_data);
            end
            if (tx_if.tx_valid && tx_if.tx_ready) got.push_back(tx_if.tx_data);
            if (done) done_cnt++;
            stall_prev = tx_if.tx_valid && !tx_if.tx_ready;
            stall_data = tx_if.tx_data;
        end
    end

    task automatic wait_done(input int budget, input bit rnd);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk); #1;
            if (rnd) tx_if.tx_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check("done_timeout", (n < budget), 1'b1);
        @(posedge clk); #1;
        tx_if.tx_ready = 1'b1;
    endtask

    task automatic compare_msg(input string tag);
        int n;
        check({tag, "_len"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
    endtask

    task automatic run_msg(input string tag, input logic [23:0] v, input bit rnd);
        int d0;
        got.delete();
        exp_q = model(v);
        d0 = done_cnt;
        results = v;
        results_valid = 1'b1;
        wait_done(800, rnd);
        results_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare_msg(tag);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        int d0;
        int n;
        logic [23:0] v;
        tx_if.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", tx_if.tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_data", tx_if.tx_data, 8'h00);
        check("rst_done", done, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Example result with latency check
        got.delete();
        exp_q = model(24'd233168);
        d0 = done_cnt;
        results = 24'd233168;
        results_valid = 1'b1;
        repeat (24) @(posedge clk);
        @(negedge clk);
        check("lat_before", tx_if.tx_valid, 1'b0);
        check("lat_busy", busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("lat_at", tx_if.tx_valid, 1'b1);
        check("lat_first", tx_if.tx_data, 8'h32);
        wait_done(200, 1'b0);
        results_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        compare_msg("m233168");
        check("m233168_done_once", done_cnt - d0, 1);

        // Boundaries
        run_msg("zero", 24'd0, 1'b0);
        run_msg("max", 24'd16777215, 1'b0);

        // Random values with random backpressure
        for (int k = 0; k < 5; k++) begin
            v = 24'($urandom_range(0, 24'hFFFFFF));
            run_msg($sformatf("rnd%0d", k), v, 1'b1);
        end
        run_msg("max_rnd", 24'd16777215, 1'b1);

        // Level held high triggers once; re-raise triggers again
        got.delete();
        exp_q = model(24'd9876);
        d0 = done_cnt;
        results = 24'd9876;
        results_valid = 1'b1;
        repeat (200) @(posedge clk); #1;
        compare_msg("hold");
        check("hold_done_once", done_cnt - d0, 1);
        results_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        run_msg("rerise", 24'd9876, 1'b0);

        // Reset in the middle of SEND
        got.delete();
        results = 24'd4242;
        results_valid = 1'b1;
        tx_if.tx_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_if.tx_valid && n < 100);
        check("rstmid_reached_send", tx_if.tx_valid, 1'b1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("rstmid_tx_valid", tx_if.tx_valid, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_tx_data", tx_if.tx_data, 8'h00);
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1;
        tx_if.tx_ready = 1'b1;
        got.delete();
        exp_q = model(24'd4242);
        d0 = done_cnt;
        wait_done(200, 1'b0);
        results_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        compare_msg("rstmid_resend");
        check("rstmid_done_once", done_cnt - d0, 1);

        // Changes while busy are ignored
        got.delete();
        exp_q = model(24'd1234567);
        d0 = done_cnt;
        results = 24'd1234567;
        results_valid = 1'b1;
        repeat (10) @(posedge clk); #1;
        results = 24'd7654321;
        results_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        results_valid = 1'b1;
        wait_done(800, 1'b1);
        repeat (40) @(posedge clk); #1;
        compare_msg("busy_ignore");
        check("busy_ignore_done_once", done_cnt - d0, 1);
        results_valid = 1'b0;
        repeat (3) @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
